alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised WIDTH-bit MIPS execute-stage ALU, successor to the single-cycle ALU.
- Keeps the combinational arithmetic, logic and compare datapath, and adds shifts, set-less-than, a signed overflow flag and NOR.
- Adds an iterative multiply/divide unit with a start/busy/done handshake that writes architectural HI/LO registers.
- Used by the multi-cycle core; the single-cycle core instantiates it with WIDTH=32 and holds start low.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data1  input  WIDTH  operand A.
- data2  input  WIDTH  operand B; its low SHW bits are the shift amount.
- aluoperation  input  4  operation select.
- start  input  1  launches a mul/div when aluoperation is 1100–1111.
- result  output  WIDTH  combinational result.
- zero  output  1  result == 0.
- lt  output  1  signed data1 < data2.
- gt  output  1  signed data1 > data2.
- ovf  output  1  signed overflow; valid for ADD and SUB only, 0 for all other operations.
- busy  output  1  mul/div in progress.
- done  output  1  one-cycle pulse; hi/lo updated on the same cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Combinational path, zero latency:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR.
  - 0110 SLT (signed) and 0111 SLTU: result is 1 or 0, zero-extended.
  - 1000 SLL, 1001 SRL, 1010 SRA: data1 shifted by data2[SHW-1:0].
  - 1011 and 1100–1111: result = data1 + data2.
- ovf:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from data1.
- lt/gt:
  - Always computed as a two's-complement comparison of data1 and data2, independent of aluoperation.
  - On equality both are 0. lt and gt are never both 1.
- Mul/div operations: 1100 MULT (signed), 1101 MULTU, 1110 DIV (signed), 1111 DIVU.
- State machine IDLE -> RUN -> FIX -> IDLE:
  - IDLE: start=1 with a mul/div op at edge N latches operand magnitudes, the op and the result signs. Go to RUN; busy=1 from edge N.
  - RUN: one iteration per edge for WIDTH edges (N+1 .. N+WIDTH). Multiply is shift-add into a 2*WIDTH accumulator; divide is restoring, one quotient bit per edge. A WIDTH-sized counter ends the phase.
  - FIX, edge N+WIDTH+1: apply signs and write hi/lo. done=1 for exactly this cycle, busy=0; return to IDLE.
  - Latency from the start edge to done is WIDTH+1 cycles. A new start is accepted in the done cycle.
- Mul/div results:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - Divide by zero (signed or unsigned): lo = all ones, hi = data1. The operation still takes the full WIDTH+1 cycles.
  - Signed min / -1: lo = min, hi = 0. No trap.
- Ignored start conditions:
  - start while busy=1: ignored; operands are not re-latched.
  - start with a non-mul/div op: ignored.
- hi/lo hold their values between operations. The combinational outputs stay live while busy.
- Reset (asynchronous, any time, including mid-operation):
  - State returns to IDLE.
  - busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - No done pulse is produced for an aborted operation.
  - Combinational outputs follow their inputs during reset.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF + 0x00000001 -> result=0x80000000, ovf=1, zero=0. SUB 5 - 5 -> result=0, zero=1, ovf=0.
- data1=0xFFFFFFFF, data2=0x00000001 -> lt=1, gt=0. SLT -> result=1; SLTU -> result=0. Equal operands -> lt=0, gt=0.
- SRA 0x80000000 by data2=0x24 (shamt 4) -> 0xF8000000. SRL -> 0x08000000. SLL 1 by 31 -> 0x80000000.
- MULT -3 × 7 with a start pulse at edge N -> busy during N..N+32, done at edge N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 9 / 0 -> lo=0xFFFFFFFF, hi=9. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start re-asserted with new operands at cycle 5 of a MULT -> ignored, original product delivered. rst asserted at cycle 10 of a DIV -> busy=0 and hi=lo=0 immediately, no done pulse; a fresh start after reset completes normally.

Source files
------------

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU: single-cycle arithmetic/logic/compare/shift datapath
// plus an iterative multiply/divide unit that writes the HI/LO registers.
module alu_muldiv #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [3:0]       aluoperation,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             lt,
   output logic             gt,
   output logic             ovf,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_e;

   // ---------------------------------------------------------------
   // Combinational datapath
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic [SHW-1:0]   shamt;

   assign add_res = data1 + data2;
   assign sub_res = data1 - data2;
   assign shamt   = data2[SHW-1:0];
   assign lt      = $signed(data1) < $signed(data2);
   assign gt      = $signed(data1) > $signed(data2);
   assign zero    = (result == '0);

   // Operation select for the single-cycle result and the signed overflow flag.
   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (aluoperation)
         4'b0000: begin
            result = add_res;
            ovf    = (data1[WIDTH-1] == data2[WIDTH-1]) && (add_res[WIDTH-1] != data1[WIDTH-1]);
         end
         4'b0001: begin
            result = sub_res;
            ovf    = (data1[WIDTH-1] != data2[WIDTH-1]) && (sub_res[WIDTH-1] != data1[WIDTH-1]);
         end
         4'b0010: result = data1 & data2;
         4'b0011: result = data1 | data2;
         4'b0100: result = data1 ^ data2;
         4'b0101: result = ~(data1 | data2);
         4'b0110: result = {{(WIDTH-1){1'b0}}, lt};
         4'b0111: result = {{(WIDTH-1){1'b0}}, (data1 < data2)};
         4'b1000: result = data1 << shamt;
         4'b1001: result = data1 >> shamt;
         4'b1010: result = $signed(data1) >>> shamt;
         default: result = add_res;
      endcase
   end

   // ---------------------------------------------------------------
   // Iterative multiply / divide
   // ---------------------------------------------------------------
   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic               div_q, div_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_r;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Signed ops (even opcodes) work on magnitudes; signs are reapplied in FIX.
   assign a_neg = ~aluoperation[0] & data1[WIDTH-1];
   assign b_neg = ~aluoperation[0] & data2[WIDTH-1];
   assign a_mag = a_neg ? -data1 : data1;
   assign b_mag = b_neg ? -data2 : data2;

   // acc holds {upper, multiplier} for multiply and {remainder, quotient} for
   // divide, so both algorithms share the same 2*WIDTH shift register.
   assign mul_addend = acc_q[0] ? opb_q : {WIDTH{1'b0}};
   assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   assign div_r      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge     = div_r >= {1'b0, opb_q};
   assign div_diff   = div_r[WIDTH-1:0] - opb_q;
   assign prod_fix   = negq_q ? -acc_q : acc_q;
   assign quo_fix    = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix    = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   // Next-state, iteration step and HI/LO write-back for the mul/div FSM.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && (aluoperation[3:2] == 2'b11)) begin
               state_d = S_RUN;
               acc_d   = {{WIDTH{1'b0}}, a_mag};
               opb_d   = b_mag;
               cnt_d   = '0;
               div_d   = aluoperation[1];
               negq_d  = a_neg ^ b_neg;
               negr_d  = a_neg;
               dz_d    = (data2 == '0);
            end
         end
         S_RUN: begin
            if (div_q) begin
               acc_d = {(div_ge ? div_diff : div_r[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH-1)) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end
         end
         S_FIX: begin
            // A zero divisor leaves remainder = |data1|, so only LO needs forcing.
            if (div_q) begin
               lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         opb_q   <= '0;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed and randomized stimulus against
// an arithmetic reference model.
module tb_alu_muldiv;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic [W-1:0] data1;
   logic [W-1:0] data2;
   logic [3:0]   aluoperation;
   logic         start;
   logic [W-1:0] result;
   logic         zero;
   logic         lt;
   logic         gt;
   logic         ovf;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks   = 0;
   int failures = 0;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .data1        (data1),
      .data2        (data2),
      .aluoperation (aluoperation),
      .start        (start),
      .result       (result),
      .zero         (zero),
      .lt           (lt),
      .gt           (gt),
      .ovf          (ovf),
      .busy         (busy),
      .done         (done),
      .hi           (hi),
      .lo           (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         z;
      logic         v;
      logic         l;
      logic         g;
   } cvec_t;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eh;
      logic [W-1:0] el;
   } mvec_t;

   // Reference for the single-cycle path, from two's-complement arithmetic.
   function automatic void ref_comb(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic v);
      longint sa, sb, wide, maxs, mins;
      int     sh;
      sa   = $signed(a);
      sb   = $signed(b);
      maxs = (longint'(1) <<< (W-1)) - 1;
      mins = -(longint'(1) <<< (W-1));
      sh   = int'(b % W);
      v    = 1'b0;
      case (op)
         4'd0: begin wide = sa + sb; r = W'(wide); v = (wide > maxs) || (wide < mins); end
         4'd1: begin wide = sa - sb; r = W'(wide); v = (wide > maxs) || (wide < mins); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~(a | b);
         4'd6: r = (sa < sb) ? W'(1) : W'(0);
         4'd7: r = (a < b) ? W'(1) : W'(0);
         4'd8: r = a << sh;
         4'd9: r = a >> sh;
         4'd10: r = W'(sa >>> sh);
         default: r = a + b;
      endcase
   endfunction

   // Reference for HI/LO results of the four mul/div operations.
   function automatic void ref_md(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl);
      longint       sa, sb, q, r;
      logic [63:0]  ua, ub, up;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (sel)
         2'd0: begin up = 64'(sa * sb); rh = up[63:32]; rl = up[31:0]; end
         2'd1: begin up = ua * ub;      rh = up[63:32]; rl = up[31:0]; end
         2'd2: begin
            if (b == 0) begin rl = '1; rh = a; end
            else begin q = sa / sb; r = sa % sb; rl = W'(q); rh = W'(r); end
         end
         default: begin
            if (b == 0) begin rl = '1; rh = a; end
            else begin rl = a / b; rh = a % b; end
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return W'($urandom_range(0, 20));
         6: return -W'($urandom_range(1, 20));
         default: return W'($urandom);
      endcase
   endfunction

   // Launch one mul/div and observe handshake timing and the delivered HI/LO.
   task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic busy_n, output logic busy_run,
                         output logic busy_done, output logic [W-1:0] rh, output logic [W-1:0] rl);
      @(negedge clk);
      data1 = a; data2 = b; aluoperation = op; start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      busy_n = busy;
      data1  = W'($urandom);
      data2  = W'($urandom);
      aluoperation = 4'($urandom_range(0, 11));
      lat = -1; busy_run = 1'b1; busy_done = 1'b1; rh = '0; rl = '0;
      for (int unsigned k = 1; k <= W + 10; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = int'(k); busy_done = busy; rh = hi; rl = lo;
            break;
         end
         if (!busy) busy_run = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; data1 = 32'd3; data2 = 32'd4; aluoperation = 4'b0000;
      #2;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
      checks++; if (result !== 32'd7) begin failures++; $display("FAIL reset_comb_live got=%h exp=7", result); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_comb_directed();
      cvec_t cv [10];
      cv[0] = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
      cv[1] = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      cv[2] = '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
      cv[3] = '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      cv[4] = '{4'hA, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0};
      cv[5] = '{4'h9, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b1, 1'b0};
      cv[6] = '{4'h8, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
      cv[7] = '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
      cv[8] = '{4'h5, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      cv[9] = '{4'hB, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         data1 = cv[i].a; data2 = cv[i].b; aluoperation = cv[i].op;
         #1;
         checks++; if (result !== cv[i].r) begin failures++; $display("FAIL dir_result[%0d] got=%h exp=%h", i, result, cv[i].r); end
         checks++; if (zero !== cv[i].z) begin failures++; $display("FAIL dir_zero[%0d] got=%b exp=%b", i, zero, cv[i].z); end
         checks++; if (ovf !== cv[i].v) begin failures++; $display("FAIL dir_ovf[%0d] got=%b exp=%b", i, ovf, cv[i].v); end
         checks++; if ({lt, gt} !== {cv[i].l, cv[i].g}) begin failures++; $display("FAIL dir_ltgt[%0d] got=%b%b exp=%b%b", i, lt, gt, cv[i].l, cv[i].g); end
      end
   endtask

   task automatic test_comb_random();
      logic [W-1:0] er;
      logic         ev;
      longint       sa, sb;
      for (int unsigned i = 0; i < 300; i++) begin
         @(negedge clk);
         data1 = pick(); data2 = pick(); aluoperation = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) data2 = data1;
         #1;
         ref_comb(aluoperation, data1, data2, er, ev);
         sa = $signed(data1); sb = $signed(data2);
         checks++; if (result !== er) begin failures++; $display("FAIL rnd_result op=%h a=%h b=%h got=%h exp=%h", aluoperation, data1, data2, result, er); end
         checks++; if (zero !== (er == 0)) begin failures++; $display("FAIL rnd_zero op=%h got=%b exp=%b", aluoperation, zero, (er == 0)); end
         checks++; if (ovf !== ev) begin failures++; $display("FAIL rnd_ovf op=%h a=%h b=%h got=%b exp=%b", aluoperation, data1, data2, ovf, ev); end
         checks++; if ({lt, gt} !== {(sa < sb), (sa > sb)}) begin failures++; $display("FAIL rnd_ltgt a=%h b=%h got=%b%b exp=%b%b", data1, data2, lt, gt, (sa < sb), (sa > sb)); end
      end
   endtask

   task automatic test_muldiv_directed();
      mvec_t        mv [7];
      int           lat;
      logic         bn, br, bd;
      logic [W-1:0] rh, rl;
      mv[0] = '{4'hC, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      mv[1] = '{4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      mv[2] = '{4'hE, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      mv[3] = '{4'hF, 32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF};
      mv[4] = '{4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      mv[5] = '{4'hE, 32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFF7, 32'hFFFFFFFF};
      mv[6] = '{4'hD, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      for (int unsigned i = 0; i < 7; i++) begin
         run_md(mv[i].op, mv[i].a, mv[i].b, lat, bn, br, bd, rh, rl);
         checks++; if (lat !== W + 1) begin failures++; $display("FAIL md_latency[%0d] got=%0d exp=%0d", i, lat, W + 1); end
         checks++; if ({bn, br, bd} !== 3'b110) begin failures++; $display("FAIL md_busy[%0d] got=%b exp=110", i, {bn, br, bd}); end
         checks++; if (rh !== mv[i].eh) begin failures++; $display("FAIL md_hi[%0d] got=%h exp=%h", i, rh, mv[i].eh); end
         checks++; if (rl !== mv[i].el) begin failures++; $display("FAIL md_lo[%0d] got=%h exp=%h", i, rl, mv[i].el); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL md_done_pulse[%0d] got=%b exp=0", i, done); end
         checks++; if ({hi, lo} !== {mv[i].eh, mv[i].el}) begin failures++; $display("FAIL md_hold[%0d] got=%h%h exp=%h%h", i, hi, lo, mv[i].eh, mv[i].el); end
      end
   endtask

   task automatic test_muldiv_random();
      int           lat;
      logic         bn, br, bd;
      logic [W-1:0] rh, rl, eh, el, a, b;
      logic [3:0]   op;
      for (int unsigned i = 0; i < 40; i++) begin
         op = 4'($urandom_range(12, 15));
         a  = pick();
         b  = pick();
         run_md(op, a, b, lat, bn, br, bd, rh, rl);
         ref_md(op[1:0], a, b, eh, el);
         checks++; if (lat !== W + 1) begin failures++; $display("FAIL rmd_latency op=%h got=%0d exp=%0d", op, lat, W + 1); end
         checks++; if (rh !== eh) begin failures++; $display("FAIL rmd_hi op=%h a=%h b=%h got=%h exp=%h", op, a, b, rh, eh); end
         checks++; if (rl !== el) begin failures++; $display("FAIL rmd_lo op=%h a=%h b=%h got=%h exp=%h", op, a, b, rl, el); end
      end
   endtask

   task automatic test_restart_ignored();
      int           lat;
      logic [W-1:0] rh, rl, eh, el;
      ref_md(2'd0, 32'h00012345, 32'hFFFF0003, eh, el);
      @(negedge clk);
      data1 = 32'h00012345; data2 = 32'hFFFF0003; aluoperation = 4'hC; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; rh = '0; rl = '0;
      for (int unsigned k = 1; k <= W + 10; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = int'(k); rh = hi; rl = lo; break; end
         if (k == 5) begin
            data1 = 32'h00000064; data2 = 32'h00000003; aluoperation = 4'hF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      checks++; if (lat !== W + 1) begin failures++; $display("FAIL restart_latency got=%0d exp=%0d", lat, W + 1); end
      checks++; if (rh !== eh) begin failures++; $display("FAIL restart_hi got=%h exp=%h", rh, eh); end
      checks++; if (rl !== el) begin failures++; $display("FAIL restart_lo got=%h exp=%h", rl, el); end
   endtask

   task automatic test_reset_abort();
      int           lat;
      logic         bn, br, bd, seen_done, seen_busy;
      logic [W-1:0] rh, rl;
      @(negedge clk);
      data1 = 32'd100; data2 = 32'd7; aluoperation = 4'hE; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if ({hi, lo} !== '0) begin failures++; $display("FAIL abort_hilo got=%h%h exp=0", hi, lo); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0; seen_busy = 1'b0;
      repeat (W + 5) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
         if (busy) seen_busy = 1'b1;
      end
      checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
      checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", seen_busy); end
      run_md(4'hE, 32'd100, 32'd7, lat, bn, br, bd, rh, rl);
      checks++; if (lat !== W + 1) begin failures++; $display("FAIL post_reset_latency got=%0d exp=%0d", lat, W + 1); end
      checks++; if ({rh, rl} !== {32'd2, 32'd14}) begin failures++; $display("FAIL post_reset_div got=%h%h exp=%h%h", rh, rl, 32'd2, 32'd14); end
   endtask

   task automatic test_back_to_back();
      int           lat;
      logic         bn, br, bd;
      logic [W-1:0] rh, rl, eh, el, a, b;
      for (int unsigned i = 0; i < 4; i++) begin
         a = pick(); b = pick();
         run_md(i[0] ? 4'hF : 4'hD, a, b, lat, bn, br, bd, rh, rl);
         ref_md(i[0] ? 2'd3 : 2'd1, a, b, eh, el);
         checks++; if (lat !== W + 1) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, W + 1); end
         checks++; if ({rh, rl} !== {eh, el}) begin failures++; $display("FAIL b2b_hilo[%0d] got=%h%h exp=%h%h", i, rh, rl, eh, el); end
      end
   endtask

   initial begin
      test_reset();
      test_comb_directed();
      test_comb_random();
      test_muldiv_directed();
      test_muldiv_random();
      test_restart_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
